// File: rtl/i2cs_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2cs_reg_bank                                                   |
// | Brief    : Slave-domain shadow/active register bank fed by the I2C master  |
// |            CDC write stream. Shadow writes become active on a commit       |
// |            (hardware pulse or control write) or immediately in imm mode.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2cs_reg_bank #(
  parameter int         REG_NUM   = 16,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] CTRL_ADDR = 8'hFF,
  parameter logic [7:0] RST_VAL   = 8'h00
) (
  input  logic                 i2cs_clk,
  input  logic                 i2cs_rst_n,
  input  logic [7:0]           i_i2cm_wr_addr,
  input  logic [7:0]           i_i2cm_wr_data,
  input  logic                 i_i2cm_wr_en,
  input  logic                 i_commit,
  input  logic [7:0]           i_reg_rd_addr,
  input  logic                 i_err_clr,
  output logic [7:0]           o_reg_rd_data,
  output logic [REG_NUM*8-1:0] o_reg_active,
  output logic                 o_pend,
  output logic                 o_commit_done,
  output logic                 o_addr_err,
  output logic [7:0]           o_wr_cnt
);

  localparam int         c_IDX_W   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [7:0] c_REG_NUM = 8'(REG_NUM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0] shadow_q [REG_NUM];
  logic [7:0] shadow_d [REG_NUM];
  logic [7:0] active_q [REG_NUM];
  logic [7:0] active_d [REG_NUM];
  logic       imm_q, imm_d;
  logic       addr_err_q, addr_err_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_data_q, rd_data_d;

  // Decode: the 8-bit offset wraps, so addresses below BASE_ADDR land out of range.
  logic [7:0]         w_wr_off;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic               w_wr_hit;
  logic               w_ctrl_wr;
  logic               w_data_wr;
  logic               w_miss_wr;
  logic               w_commit_req;
  logic [7:0]         w_rd_off;
  logic [c_IDX_W-1:0] w_rd_idx;

  assign w_wr_off     = i_i2cm_wr_addr - BASE_ADDR;
  assign w_wr_idx     = w_wr_off[c_IDX_W-1:0];
  assign w_wr_hit     = (w_wr_off < c_REG_NUM);
  assign w_data_wr    = i_i2cm_wr_en && w_wr_hit;
  assign w_ctrl_wr    = i_i2cm_wr_en && !w_wr_hit && (i_i2cm_wr_addr == CTRL_ADDR);
  assign w_miss_wr    = i_i2cm_wr_en && !w_wr_hit && (i_i2cm_wr_addr != CTRL_ADDR);
  assign w_commit_req = i_commit || (w_ctrl_wr && i_i2cm_wr_data[1]);
  assign w_rd_off     = i_reg_rd_addr - BASE_ADDR;
  assign w_rd_idx     = w_rd_off[c_IDX_W-1:0];

  // Commit FSM next state; a write inside COMMIT re-arms PEND for the next copy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_data_wr && !imm_q) state_d = ST_PEND;
      ST_PEND:   if (w_commit_req)        state_d = ST_COMMIT;
      ST_COMMIT: state_d = (w_data_wr && !imm_q) ? ST_PEND : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Register-file next state: commit copies pre-write shadow, immediate write overrides.
  always_comb begin
    for (int k = 0; k < REG_NUM; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = state_q == ST_COMMIT ? shadow_q[k] : active_q[k];
    end
    imm_d      = imm_q;
    addr_err_d = addr_err_q;
    wr_cnt_d   = wr_cnt_q;
    if (w_data_wr) begin
      shadow_d[w_wr_idx] = i_i2cm_wr_data;
      if (imm_q) active_d[w_wr_idx] = i_i2cm_wr_data;
      wr_cnt_d = wr_cnt_q + 8'd1;
    end
    if (w_ctrl_wr) imm_d = i_i2cm_wr_data[0];
    if (w_miss_wr)      addr_err_d = 1'b1;
    else if (i_err_clr) addr_err_d = 1'b0;
  end

  // Read mux, registered on the next edge.
  always_comb begin
    rd_data_d = 8'h00;
    if (w_rd_off < c_REG_NUM)          rd_data_d = active_q[w_rd_idx];
    else if (i_reg_rd_addr == CTRL_ADDR) rd_data_d = {6'b0, o_pend, imm_q};
  end

  // State and storage registers; reset abandons any in-flight commit.
  always_ff @(posedge i2cs_clk or negedge i2cs_rst_n) begin
    if (!i2cs_rst_n) begin
      state_q    <= ST_IDLE;
      imm_q      <= 1'b0;
      addr_err_q <= 1'b0;
      wr_cnt_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      for (int k = 0; k < REG_NUM; k++) begin
        shadow_q[k] <= RST_VAL;
        active_q[k] <= RST_VAL;
      end
    end else begin
      state_q    <= state_d;
      imm_q      <= imm_d;
      addr_err_q <= addr_err_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_data_q  <= rd_data_d;
      for (int k = 0; k < REG_NUM; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  generate
    for (genvar k = 0; k < REG_NUM; k++) begin : g_active_bus
      assign o_reg_active[8*k +: 8] = active_q[k];
    end
  endgenerate

  // Pending is PEND state only: a COMMIT without a fresh write drains to IDLE.
  assign o_pend        = (state_q == ST_PEND);
  assign o_commit_done = (state_q == ST_COMMIT);
  assign o_addr_err    = addr_err_q;
  assign o_wr_cnt      = wr_cnt_q;
  assign o_reg_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2cs_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2cs_reg_bank                                                |
// | Brief    : Directed self-checking bench for i2cs_reg_bank (defaults).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_i2cs_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   wr_addr = 8'h00;
  logic [7:0]   wr_data = 8'h00;
  logic         wr_en = 1'b0;
  logic         commit = 1'b0;
  logic [7:0]   rd_addr = 8'h00;
  logic         err_clr = 1'b0;
  logic [7:0]   rd_data;
  logic [127:0] active;
  logic         pend;
  logic         commit_done;
  logic         addr_err;
  logic [7:0]   wr_cnt;

  int total = 0;
  int bad   = 0;

  i2cs_reg_bank dut (
    .i2cs_clk       (clk),
    .i2cs_rst_n     (rst_n),
    .i_i2cm_wr_addr (wr_addr),
    .i_i2cm_wr_data (wr_data),
    .i_i2cm_wr_en   (wr_en),
    .i_commit       (commit),
    .i_reg_rd_addr  (rd_addr),
    .i_err_clr      (err_clr),
    .o_reg_rd_data  (rd_data),
    .o_reg_active   (active),
    .o_pend         (pend),
    .o_commit_done  (commit_done),
    .o_addr_err     (addr_err),
    .o_wr_cnt       (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_addr = a;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    total++; if (active !== 128'h0) begin bad++; $display("FAIL reset_active got=%h exp=0", active); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pend); end
    total++; if (wr_cnt !== 8'h00) begin bad++; $display("FAIL reset_wrcnt got=%h exp=00", wr_cnt); end
    total++; if ({commit_done, addr_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {commit_done, addr_err}); end
    rd(8'h03);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_read got=%h exp=00", rd_data); end
  endtask

  task automatic test_commit();
    wr(8'h02, 8'hA5);
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL commit_pend_set got=%b exp=1", pend); end
    total++; if (active[23:16] !== 8'h00) begin bad++; $display("FAIL commit_pre got=%h exp=00", active[23:16]); end
    commit = 1'b1; cyc(); commit = 1'b0;
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL commit_done got=%b exp=1", commit_done); end
    total++; if (active[23:16] !== 8'h00) begin bad++; $display("FAIL commit_n1 got=%h exp=00", active[23:16]); end
    cyc();
    total++; if (active[23:16] !== 8'hA5) begin bad++; $display("FAIL commit_n2 got=%h exp=a5", active[23:16]); end
    total++; if ({pend, commit_done} !== 2'b00) begin bad++; $display("FAIL commit_after got=%b exp=00", {pend, commit_done}); end
    rd(8'h02);
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL commit_read got=%h exp=a5", rd_data); end
    total++; if (wr_cnt !== 8'h01) begin bad++; $display("FAIL commit_wrcnt got=%h exp=01", wr_cnt); end
  endtask

  task automatic test_idle_commit();
    commit = 1'b1; cyc(); commit = 1'b0;
    total++; if (commit_done !== 1'b0) begin bad++; $display("FAIL idle_commit got=%b exp=0", commit_done); end
  endtask

  task automatic test_imm();
    wr(8'hFF, 8'h01);
    wr(8'h05, 8'h3C);
    total++; if (active[47:40] !== 8'h3C) begin bad++; $display("FAIL imm_active got=%h exp=3c", active[47:40]); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL imm_pend got=%b exp=0", pend); end
    rd(8'hFF);
    total++; if (rd_data !== 8'h01) begin bad++; $display("FAIL imm_ctrl_read got=%h exp=01", rd_data); end
    total++; if (wr_cnt !== 8'h02) begin bad++; $display("FAIL imm_wrcnt got=%h exp=02", wr_cnt); end
    wr(8'hFF, 8'h00);
  endtask

  task automatic test_write_in_commit();
    wr(8'h01, 8'h11);
    wr(8'hFF, 8'h02);
    wr_addr = 8'h01; wr_data = 8'h77; wr_en = 1'b1;
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL swcommit_done got=%b exp=1", commit_done); end
    cyc(); wr_en = 1'b0;
    total++; if (active[15:8] !== 8'h11) begin bad++; $display("FAIL wic_active got=%h exp=11", active[15:8]); end
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL wic_pend got=%b exp=1", pend); end
    commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    total++; if (active[15:8] !== 8'h77) begin bad++; $display("FAIL wic_second got=%h exp=77", active[15:8]); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL wic_pend_clr got=%b exp=0", pend); end
  endtask

  task automatic test_back_to_back();
    wr(8'h03, 8'h10);
    wr_addr = 8'h03; wr_data = 8'h20; wr_en = 1'b1; commit = 1'b1;
    cyc(); wr_en = 1'b0; commit = 1'b0;
    cyc();
    total++; if (active[31:24] !== 8'h20) begin bad++; $display("FAIL b2b_active got=%h exp=20", active[31:24]); end
    total++; if (wr_cnt !== 8'h06) begin bad++; $display("FAIL b2b_wrcnt got=%h exp=06", wr_cnt); end
  endtask

  task automatic test_addr_err();
    logic [127:0] snap;
    snap = active;
    wr(8'h40, 8'h99);
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", addr_err); end
    total++; if (wr_cnt !== 8'h06) begin bad++; $display("FAIL err_wrcnt got=%h exp=06", wr_cnt); end
    total++; if (active !== 128'h0000_0000_0000_0000_0000_3C00_20A5_7700) begin bad++; $display("FAIL err_active got=%h exp=%h", active, snap); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL err_pend got=%b exp=0", pend); end
    wr_addr = 8'h10; wr_en = 1'b1; err_clr = 1'b1;
    cyc(); wr_en = 1'b0;
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL err_set_wins got=%b exp=1", addr_err); end
    cyc(); err_clr = 1'b0;
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", addr_err); end
  endtask

  task automatic test_imm_while_pend();
    wr(8'h04, 8'h44);
    wr(8'hFF, 8'h01);
    total++; if (active[39:32] !== 8'h00) begin bad++; $display("FAIL imp_noflush got=%h exp=00", active[39:32]); end
    rd(8'hFF);
    total++; if (rd_data !== 8'h03) begin bad++; $display("FAIL imp_ctrl_read got=%h exp=03", rd_data); end
    wr(8'h06, 8'h66);
    total++; if (active[55:48] !== 8'h66) begin bad++; $display("FAIL imp_imm got=%h exp=66", active[55:48]); end
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL imp_pend got=%b exp=1", pend); end
    commit = 1'b1; cyc(); commit = 1'b0;
    cyc();
    total++; if (active[39:32] !== 8'h44) begin bad++; $display("FAIL imp_commit got=%h exp=44", active[39:32]); end
    wr(8'hFF, 8'h00);
  endtask

  task automatic test_wrap_and_reset();
    // Eight counted writes so far; 247 more reach 8'hFF, one more wraps.
    for (int i = 0; i < 247; i++) wr(8'h00, 8'(i));
    total++; if (wr_cnt !== 8'hFF) begin bad++; $display("FAIL wrap_ff got=%h exp=ff", wr_cnt); end
    wr(8'h00, 8'hEE);
    total++; if (wr_cnt !== 8'h00) begin bad++; $display("FAIL wrap_00 got=%h exp=00", wr_cnt); end
    commit = 1'b1; cyc(); commit = 1'b0;
    total++; if (commit_done !== 1'b1) begin bad++; $display("FAIL rstc_in_commit got=%b exp=1", commit_done); end
    rst_n = 1'b0;
    #1;
    total++; if (active !== 128'h0) begin bad++; $display("FAIL rstc_active got=%h exp=0", active); end
    total++; if ({commit_done, pend} !== 2'b00) begin bad++; $display("FAIL rstc_flags got=%b exp=00", {commit_done, pend}); end
    cyc();
    rst_n = 1'b1;
    cyc();
    total++; if (active[7:0] !== 8'h00) begin bad++; $display("FAIL rstc_abandon got=%h exp=00", active[7:0]); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_idle_commit();
    test_imm();
    test_write_in_commit();
    test_back_to_back();
    test_addr_err();
    test_imm_while_pend();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
